// File: rtl/nibble_serial_addsub_pkg.sv
// Shared types and helpers for the nibble-serial add/sub sequencer.
// Holds the FSM state type, the nibble width and the nibble-select function.
package nibble_serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int NIBBLE_W = 4;
  localparam int MAX_W    = 64;

  function automatic logic [NIBBLE_W-1:0] nib_sel(
    input logic [MAX_W-1:0] v,
    input int unsigned      idx
  );
    return v[idx*NIBBLE_W +: NIBBLE_W];
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_if.sv
// Operand/result handshakes plus the link to the external 4-bit add/sub unit.
// The slave side is the sequencer; the master side is its environment.
interface nibble_serial_addsub_if
  import nibble_serial_addsub_pkg::*;
#(
  parameter int NIBBLES = 4
);

  localparam int W = NIBBLE_W * NIBBLES;

  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        in_a;
  logic [W-1:0]        in_b;
  logic                in_sub;

  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        out_f;
  logic                out_cf;
  logic                out_zf;
  logic                out_of;

  logic [NIBBLE_W-1:0] alu_a;
  logic [NIBBLE_W-1:0] alu_b;
  logic                alu_c0;
  logic                alu_as;
  logic [NIBBLE_W-1:0] alu_f;
  logic                alu_c4;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_a,
    input  in_b,
    input  in_sub,
    output out_valid,
    input  out_ready,
    output out_f,
    output out_cf,
    output out_zf,
    output out_of,
    output alu_a,
    output alu_b,
    output alu_c0,
    output alu_as,
    input  alu_f,
    input  alu_c4
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_a,
    output in_b,
    output in_sub,
    input  out_valid,
    output out_ready,
    input  out_f,
    input  out_cf,
    input  out_zf,
    input  out_of,
    input  alu_a,
    input  alu_b,
    input  alu_c0,
    input  alu_as,
    output alu_f,
    output alu_c4
  );

endinterface

// File: rtl/nibble_serial_addsub.sv
// W-bit add/sub sequenced over an external 4-bit unit, LSB nibble first.
// One operation in flight: accept, NIBBLES run cycles, then hold the result.
module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  nibble_serial_addsub_if.slave   bus
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             sub_q;
  logic             carry_q;
  logic [W-1:0]     res_q;

  logic             in_ready_q;
  logic             out_valid_q;
  logic [W-1:0]     out_f_q;
  logic             out_cf_q;
  logic             out_zf_q;
  logic             out_of_q;

  logic [W-1:0]     f_full;
  logic             beff_msb;
  logic             of_next;

  // Result with the nibble being computed this cycle merged in
  always_comb begin
    f_full = res_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        f_full[i*NIBBLE_W +: NIBBLE_W] = bus.alu_f;
      end
    end
  end

  always_comb begin
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    bus.alu_c0 = 1'b0;
    bus.alu_as = 1'b0;
    if (state_q == RUN) begin
      bus.alu_a  = nib_sel(MAX_W'(a_q), 32'(idx_q));
      bus.alu_b  = nib_sel(MAX_W'(b_q), 32'(idx_q));
      bus.alu_c0 = carry_q;
      bus.alu_as = sub_q;
    end
  end

  assign beff_msb = sub_q ? ~b_q[W-1] : b_q[W-1];
  assign of_next  = (a_q[W-1] == beff_msb)
                 && (f_full[W-1] != a_q[W-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_f_q     <= '0;
      out_cf_q    <= 1'b0;
      out_zf_q    <= 1'b0;
      out_of_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.in_a;
            b_q        <= bus.in_b;
            sub_q      <= bus.in_sub;
            carry_q    <= bus.in_sub;
            idx_q      <= '0;
            res_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          res_q   <= f_full;
          carry_q <= bus.alu_c4;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            out_valid_q <= 1'b1;
            out_f_q     <= f_full;
            out_cf_q    <= bus.alu_c4 ^ sub_q;
            out_zf_q    <= (f_full == '0);
            out_of_q    <= of_next;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // in_valid is ignored here even alongside out_ready
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_f     = out_f_q;
  assign bus.out_cf    = out_cf_q;
  assign bus.out_zf    = out_zf_q;
  assign bus.out_of    = out_of_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Bench for nibble_serial_addsub paired with a behavioural 4-bit add/sub unit.
// Table of directed vectors plus back-pressure and mid-run reset sequences.
module tb_nibble_serial_addsub;

  localparam int NIB = 4;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] f;
    logic        cf;
    logic        zf;
    logic        of;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  nibble_serial_addsub_if #(.NIBBLES(NIB)) bus ();

  nibble_serial_addsub #(.NIBBLES(NIB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [4:0] alu_sum;
  logic [3:0] alu_bx;
  assign alu_bx     = bus.alu_as ? ~bus.alu_b : bus.alu_b;
  assign alu_sum    = {1'b0, bus.alu_a} + {1'b0, alu_bx}
                    + {4'b0, bus.alu_c0};
  assign bus.alu_f  = alu_sum[3:0];
  assign bus.alu_c4 = alu_sum[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operand and return once the accepting edge has passed
  task automatic send(input logic [15:0] a,
                      input logic [15:0] b,
                      input logic        s);
    int n;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = s;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    check("accept_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // lat counts edges from the accepting edge (as 1) to out_valid
  task automatic wait_result(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  vec_t vecs [7];

  initial begin
    int lat;
    logic [15:0] held_f;

    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b0;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 0, 0, 0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1, 1, 0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 0, 0, 1};
    vecs[3] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1, 0, 0};
    vecs[4] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 0, 1, 0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 0, 0, 1};
    vecs[6] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 0, 0, 0};

    tick();
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_f", 32'(bus.out_f), 32'd0);
    check("rst_alu_a", 32'(bus.alu_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].sub);
      wait_result(lat);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'd5);
      check($sformatf("v%0d_f", i), 32'(bus.out_f),
            32'(vecs[i].f));
      check($sformatf("v%0d_cf", i), 32'(bus.out_cf),
            32'(vecs[i].cf));
      check($sformatf("v%0d_zf", i), 32'(bus.out_zf),
            32'(vecs[i].zf));
      check($sformatf("v%0d_of", i), 32'(bus.out_of),
            32'(vecs[i].of));
      consume();
    end

    // Back-pressure with a second request held throughout
    send(16'h0010, 16'h0020, 1'b0);
    wait_result(lat);
    held_f       = 16'h0030;
    bus.in_a     = 16'h0101;
    bus.in_b     = 16'h0202;
    bus.in_sub   = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("bp%0d_valid", k),
            32'(bus.out_valid), 32'd1);
      check($sformatf("bp%0d_f", k), 32'(bus.out_f),
            32'(held_f));
      check($sformatf("bp%0d_in_ready", k),
            32'(bus.in_ready), 32'd0);
    end
    consume();
    check("bp_idle_ready", 32'(bus.in_ready), 32'd1);
    check("bp_idle_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("bp_second_taken", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    wait_result(lat);
    check("bp_second_lat", 32'(lat), 32'd5);
    check("bp_second_f", 32'(bus.out_f), 32'h0303);
    consume();

    // Reset during the second RUN cycle
    send(16'h5A5A, 16'h1111, 1'b1);
    tick();
    check("run2_alu_a", 32'(bus.alu_a), 32'h5);
    check("run2_alu_as", 32'(bus.alu_as), 32'd1);
    rst = 1'b1;
    #1;
    check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mrst_alu", {26'd0, bus.alu_a, bus.alu_c0, bus.alu_as},
          32'd0);
    check("mrst_alu_b", 32'(bus.alu_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    send(16'h0001, 16'h0001, 1'b0);
    wait_result(lat);
    check("post_rst_lat", 32'(lat), 32'd5);
    check("post_rst_f", 32'(bus.out_f), 32'h0002);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
